// File: rtl/riscv_pkg.sv
// Shared types for the writeback slice.
//   mem_read_t : load size encoding carried in control_t.mem_read
//   control_t  : per-instruction writeback control bundle
//   wb_state_t : writeback unit FSM states
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_B    = 2'b01,
        MEM_H    = 2'b10,
        MEM_W    = 2'b11
    } mem_read_t;

    typedef struct packed {
        mem_read_t mem_read;
        logic      mem_unsigned;
        logic      wb_pc;
        logic      reg_write;
    } control_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data alignment and extension.
// Ports:
//   data        [XLEN-1:0] raw memory response word
//   addr_lo     [1:0]      low address bits of the load
//   size        [1:0]      mem_read encoding (MEM_B / MEM_H / MEM_W)
//   is_unsigned            1 = zero-extend, 0 = sign-extend
//   result      [XLEN-1:0] aligned, extended load value
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
        word_sel = data[31:0];
    end

    always_comb begin
        result = '0;
        case (size)
            MEM_B:   result = {{(XLEN-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_H:   result = {{(XLEN-16){~is_unsigned & half_sel[15]}}, half_sel};
            MEM_W: begin
                if (XLEN > 32) begin
                    result = {{(XLEN-32){~is_unsigned & word_sel[31]}}, word_sel};
                end else begin
                    result = XLEN'(word_sel);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage; writes ALU/PC+4 results directly and
// waits for the data-memory response on loads before writing back.
// Optional feature macro: WB_INSTRET_EN adds the instret retire counter port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        instruction handshake (ready only in IDLE)
//   control                    control_t bundle (mem_read, mem_unsigned, wb_pc, reg_write)
//   pc_wb, alu_res [XLEN]      instruction PC and ALU result
//   addr_lo [2], rd [5]        load address low bits, destination register
//   mem_rsp_valid/mem_rsp_data load response
//   wb_valid, wb_we, wb_rd, wb_data  registered register-file write port
//   instret [INSTRET_W]        retired count (WB_INSTRET_EN only)
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  control_t             control,
    input  logic [XLEN-1:0]      pc_wb,
    input  logic [XLEN-1:0]      alu_res,
    input  logic [1:0]           addr_lo,
    input  logic [4:0]           rd,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    wb_state_t       state_q, state_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic [1:0]      pend_addr_q, pend_addr_d;
    mem_read_t       pend_size_q, pend_size_d;
    logic            pend_uns_q, pend_uns_d;
    logic            pend_we_q, pend_we_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [XLEN-1:0] load_data;
    logic            accept;

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .data       (mem_rsp_data),
        .addr_lo    (pend_addr_q),
        .size       (pend_size_q),
        .is_unsigned(pend_uns_q),
        .result     (load_data)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        pend_size_d = pend_size_q;
        pend_uns_d  = pend_uns_q;
        pend_we_d   = pend_we_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;

        case (state_q)
            IDLE: begin
                // Responses seen here (including one in the acceptance cycle)
                // belong to no pending load and are dropped.
                if (accept) begin
                    if (control.mem_read == MEM_NONE) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_we_d    = control.reg_write && (rd != 5'd0);
                        wb_data_d  = control.wb_pc ? (pc_wb + XLEN'(4)) : alu_res;
                    end else begin
                        pend_rd_d   = rd;
                        pend_addr_d = addr_lo;
                        pend_size_d = control.mem_read;
                        pend_uns_d  = control.mem_unsigned;
                        pend_we_d   = control.reg_write;
                        state_d     = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = pend_rd_q;
                    wb_we_d    = pend_we_q && (pend_rd_q != 5'd0);
                    wb_data_d  = load_data;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_addr_q <= '0;
            pend_size_q <= MEM_NONE;
            pend_uns_q  <= 1'b0;
            pend_we_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_addr_q <= pend_addr_d;
            pend_size_q <= pend_size_d;
            pend_uns_q  <= pend_uns_d;
            pend_we_q   <= pend_we_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    // Counts the visible writeback pulse, so it lags the acceptance by one edge.
    always_comb begin
        instret_d = instret_q + INSTRET_W'(wb_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed self-checking bench for writeback_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_writeback_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    control_t    control;
    logic [31:0] pc_wb;
    logic [31:0] alu_res;
    logic [1:0]  addr_lo;
    logic [4:0]  rd;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_INSTRET_EN
    logic [3:0]  instret;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    writeback_unit #(
        .XLEN     (32),
        .INSTRET_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .control      (control),
        .pc_wb        (pc_wb),
        .alu_res      (alu_res),
        .addr_lo      (addr_lo),
        .rd           (rd),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
`ifdef WB_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    // Presents one instruction; caller advances the clock.
    task automatic drive(input mem_read_t mr, input logic uns, input logic wbpc,
                         input logic rw, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [1:0] alo, input logic [4:0] rdv);
        in_valid             = 1'b1;
        control.mem_read     = mr;
        control.mem_unsigned = uns;
        control.wb_pc        = wbpc;
        control.reg_write    = rw;
        pc_wb                = pc;
        alu_res              = alu;
        addr_lo              = alo;
        rd                   = rdv;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef WB_INSTRET_EN
        n_checks++; if (instret !== 4'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
`endif
    endtask

    task automatic test_alu();
        drive(MEM_NONE, 1'b0, 1'b0, 1'b1, 32'h100, 32'h1234, 2'd0, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b want 1", wb_we); end
        n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", wb_rd); end
        n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_data: got %h want 00001234", wb_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle: got %b want 0", wb_valid); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %b want 0", wb_we); end
        n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_data_hold: got %h want 00001234", wb_data); end
        n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd_hold: got %0d want 5", wb_rd); end
    endtask

    task automatic test_jal();
        drive(MEM_NONE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hAAAA_5555, 2'd0, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL jal_wrap: got %h want 00000000", wb_data); end
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL jal_valid: got %b want 1", wb_valid); end
        drive(MEM_NONE, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h1, 2'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (wb_data !== 32'h0000_2004) begin n_fail++; $display("FAIL jal_pc4: got %h want 00002004", wb_data); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL jal_no_regwrite_we: got %b want 0", wb_we); end
    endtask

    task automatic test_lb_signed();
        // Response asserted in the acceptance cycle must be ignored.
        drive(MEM_B, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd2, 5'd7);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_accept_rsp_ignored: got %b want 0", wb_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_wait_ready[%0d]: got %b want 0", i, in_ready); end
            if (i == 2) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'h0080_FF11;
            end
            @(negedge clk);
        end
        idle_inputs();
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lb_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", wb_data); end
        n_checks++; if (wb_rd !== 5'd7) begin n_fail++; $display("FAIL lb_rd: got %0d want 7", wb_rd); end
        n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL lb_we: got %b want 1", wb_we); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_after: got %b want 1", in_ready); end
    endtask

    // Issues a load with a one-cycle response latency.
    task automatic do_load(input mem_read_t mr, input logic uns, input logic [1:0] alo,
                           input logic [4:0] rdv, input logic [31:0] rsp);
        drive(mr, uns, 1'b0, 1'b1, 32'h0, 32'h0, alo, rdv);
        @(negedge clk);
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load_sizes();
        do_load(MEM_H, 1'b1, 2'd3, 5'd9, 32'h8001_7F00);
        n_checks++; if (wb_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", wb_data); end
        n_checks++; if (wb_rd !== 5'd9) begin n_fail++; $display("FAIL lhu_rd: got %0d want 9", wb_rd); end
        do_load(MEM_H, 1'b0, 2'd0, 5'd10, 32'h1234_8765);
        n_checks++; if (wb_data !== 32'hFFFF_8765) begin n_fail++; $display("FAIL lh_data: got %h want ffff8765", wb_data); end
        do_load(MEM_B, 1'b1, 2'd1, 5'd11, 32'h0000_8000);
        n_checks++; if (wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", wb_data); end
        do_load(MEM_B, 1'b0, 2'd3, 5'd12, 32'h7F00_0000);
        n_checks++; if (wb_data !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos_data: got %h want 0000007f", wb_data); end
        do_load(MEM_W, 1'b0, 2'd1, 5'd0, 32'hDEAD_BEEF);
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lw_rd0_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL lw_rd0_we: got %b want 0", wb_we); end
        n_checks++; if (wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", wb_data); end
    endtask

    task automatic test_idle_rsp();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idle_rsp_data_hold: got %h want deadbeef", wb_data); end
    endtask

    task automatic test_rst_wait();
        drive(MEM_W, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_F00D;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_valid: got %b want 0", wb_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready: got %b want 1", in_ready); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_wait_data: got %h want 0", wb_data); end
        // Reset wins over a simultaneous acceptance.
        drive(MEM_NONE, 1'b0, 1'b0, 1'b1, 32'h0, 32'h77, 2'd0, 5'd6);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_prio_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_prio_rd: got %0d want 0", wb_rd); end
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_prio_late: got %b want 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        drive(MEM_NONE, 1'b0, 1'b0, 1'b1, 32'h0, 32'hA1, 2'd0, 5'd2);
        @(negedge clk);
        n_checks++; if (wb_data !== 32'hA1) begin n_fail++; $display("FAIL b2b_first_data: got %h want 000000a1", wb_data); end
        drive(MEM_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'hB2, 2'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_data !== 32'hB2) begin n_fail++; $display("FAIL b2b_second_data: got %h want 000000b2", wb_data); end
        n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL b2b_second_rd: got %0d want 3", wb_rd); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL b2b_second_we: got %b want 0", wb_we); end
        @(negedge clk);
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        drive(MEM_NONE, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 2'd0, 5'd1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (instret !== 4'd0) begin n_fail++; $display("FAIL instret_16_wrap: got %0d want 0", instret); end
        @(negedge clk);
        n_checks++; if (instret !== 4'd1) begin n_fail++; $display("FAIL instret_17: got %0d want 1", instret); end
        @(negedge clk);
        n_checks++; if (instret !== 4'd1) begin n_fail++; $display("FAIL instret_hold: got %0d want 1", instret); end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        control       = '0;
        pc_wb         = '0;
        alu_res       = '0;
        addr_lo       = '0;
        rd            = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        test_reset();
        test_alu();
        test_jal();
        test_lb_signed();
        test_load_sizes();
        test_idle_rsp();
        test_rst_wait();
        test_back_to_back();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values are 32 and 64.
REQ-002 Parameter INSTRET_W, default 64: retire counter width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: instruction presented this cycle.
REQ-006 Port in_ready, output, 1: unit accepts the instruction this cycle.
REQ-007 Port control, input, control_t: fields mem_read[1:0], mem_unsigned, wb_pc, reg_write.
REQ-008 Ports pc_wb, alu_res, input, XLEN: instruction PC and ALU result.
REQ-009 Port addr_lo, input, 2: low address bits of the load.
REQ-010 Port rd, input, 5: destination register.
REQ-011 Ports mem_rsp_valid (input, 1) and mem_rsp_data (input, XLEN): data-memory load response.
REQ-012 Ports wb_valid (output, 1), wb_we (output, 1), wb_rd (output, 5), wb_data (output, XLEN): registered register-file write port.
REQ-013 Port instret, output, INSTRET_W: retired-instruction count (present only with WB_INSTRET_EN).

Function
REQ-014 The unit SHALL have two states: IDLE and WAIT_RSP.
REQ-015 in_ready SHALL equal (state==IDLE), combinationally.
REQ-016 Acceptance SHALL occur when in_valid && in_ready.
REQ-017 Non-load acceptance (mem_read==00) at cycle N SHALL assert wb_valid for exactly cycle N+1; the state stays IDLE.
REQ-018 Non-load wb_data SHALL be pc_wb+4, truncated to XLEN (wraps), when wb_pc=1; otherwise it SHALL be alu_res.
REQ-019 Load acceptance SHALL capture rd, addr_lo, mem_read, mem_unsigned and reg_write, then enter WAIT_RSP.
REQ-020 In WAIT_RSP, mem_rsp_valid at cycle M SHALL return the state to IDLE and assert wb_valid at M+1, with wb_data equal to the aligned load data.
REQ-021 A response arriving in the acceptance cycle SHALL be ignored.
REQ-022 Load alignment, mem_read=01 (byte): select byte addr_lo of mem_rsp_data.
REQ-023 Load alignment, mem_read=10 (half): select halfword addr_lo[1]; addr_lo[0] is ignored.
REQ-024 Load alignment, mem_read=11 (word): use the low 32 bits; addr_lo is ignored.
REQ-025 Aligned load data SHALL be sign-extended to XLEN when mem_unsigned=0 and zero-extended otherwise.
REQ-026 mem_rsp_valid while IDLE SHALL be ignored, with no output effect.
REQ-027 wb_we SHALL equal wb_valid && reg_write && (wb_rd!=0).
REQ-028 An instruction with rd=0 SHALL still produce wb_valid.
REQ-029 wb_rd, wb_data and wb_we SHALL hold their value while wb_valid=0; wb_we SHALL be 0 whenever wb_valid=0.

Reset
REQ-030 rst SHALL force state=IDLE, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0 and instret=0 on the next edge.
REQ-031 rst during WAIT_RSP SHALL discard the pending load; a response in the cycle after reset SHALL be ignored.
REQ-032 rst SHALL take priority over acceptance and response in the same cycle.

Configuration
REQ-033 With WB_INSTRET_EN defined: instret SHALL increment by 1 on every cycle with wb_valid=1, wrapping modulo 2^INSTRET_W.
REQ-034 Without WB_INSTRET_EN: no instret port and no counter logic SHALL exist.

Structure
REQ-035 Package riscv_pkg SHALL hold:
- control_t
- mem_read encodings (MEM_NONE, MEM_B, MEM_H, MEM_W)
- wb_state_t enum
REQ-036 Load alignment and extension SHALL be a combinational sub-module load_align (inputs: data, addr_lo, size, unsigned; output: XLEN result).

Verification
REQ-037 ALU op: alu_res=0x1234, rd=5, reg_write=1 accepted at cycle 3 -> cycle 4 shows wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234.
REQ-038 JAL: pc_wb=0xFFFFFFFC, wb_pc=1 -> wb_data=0x00000000 (wrap).
REQ-039 LB signed: addr_lo=2, response 0x0080FF11 arrives 3 cycles after acceptance -> in_ready=0 for those 3 cycles, then wb_data=0xFFFFFF80.
REQ-040 LHU: addr_lo=3, response 0x8001_7F00 -> wb_data=0x00008001; LW to rd=0 -> wb_valid=1, wb_we=0.
REQ-041 rst asserted in WAIT_RSP, then a response next cycle -> no wb_valid, and in_ready=1.
REQ-042 WB_INSTRET_EN with INSTRET_W=4: 17 retirements -> instret=1.
